// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage arithmetic units: operand width,
// divide-unit operation encodings and the divider state machine states.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes. The partial
// remainder and the dividend/quotient register shift left together; the
// divisor is subtracted from the shifted remainder one bit wider than XLEN so
// the borrow bit decides whether the subtraction is kept.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Since rem < divisor on entry, a kept trial always fits in XLEN bits and
  // the top trial bit is a valid borrow even when shifted[XLEN] is set.
  assign shifted  = {rem, quo[XLEN-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU). Operands are
// latched on start, converted to magnitudes for signed ops, divided over 32
// restoring iterations, then sign-corrected and registered in a final cycle.
// Divide-by-zero and signed overflow skip the iterations and finish one edge
// after start.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import alu_pkg::*;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate when n is set; 0x80000000 maps to itself, which
  // is exactly the unsigned 2^31 magnitude the datapath expects.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  div_state_e      state, state_nxt;
  logic [4:0]      cnt;
  logic [XLEN-1:0] rem, quo, dvs;
  logic [XLEN-1:0] rem_step, quo_step;
  logic            neg_q, neg_r, sel_rem;

  logic            is_signed, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign a_neg     = is_signed && a[XLEN-1];
  assign b_neg     = is_signed && b[XLEN-1];
  assign a_mag     = neg_if(a, a_neg);
  assign b_mag     = neg_if(b, b_neg);
  assign div_zero  = (b == '0);
  assign ovf       = is_signed && (a == MIN_INT) && (b == '1);
  assign special   = div_zero || ovf;
  assign busy      = (state != IDLE);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: special cases jump straight to FIX with preloaded results
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? FIX : CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, sign fix-up and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_rem <= op[1];
            cnt     <= '0;
            dvs     <= b_mag;
            if (div_zero) begin
              quo   <= '1;
              rem   <= a;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (ovf) begin
              quo   <= MIN_INT;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo   <= a_mag;
              rem   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          result <= sel_rem ? neg_if(rem, neg_r) : neg_if(quo, neg_q);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
